fifo_rd_prefetch: RTL

Read-side prefetch adapter placed directly downstream of the ping-pong single-port FIFO. It issues `RE` pulses into the FIFO and captures each `res`/`read_valid` response into a small in-order skid buffer. It then presents the words to the consumer on a valid/ready stream. Read credits prevent over-reading, and an empty-FIFO `r_err` response triggers a retry backoff, so the consumer never sees the FIFO's `32'hffffffff` filler or its variable read latency.

---
 rtl/fifo_rd_prefetch_pkg.sv | 18 +
 rtl/fifo_rd_prefetch_rd_skid_buf.sv | 74 +++++++
 rtl/fifo_rd_prefetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_prefetch_pkg.sv
// Shared definitions for the FIFO read-side prefetch adapter:
// FSM state encoding, data word width and the inflight-counter width helper.
package fifo_rd_prefetch_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BACKOFF = 2'd2
  } rd_state_e;

  // Width able to hold 0..depth inclusive (request count or occupancy).
  function automatic int infl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_prefetch_rd_skid_buf.sv
// In-order skid buffer behind the FIFO read port. Circular storage with
// power-of-two depth; push and pop may coincide at any occupancy, including
// full, because the pop frees the slot the push is about to use.
module rd_skid_buf
  import fifo_rd_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     occ_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = infl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [OW-1:0]    occ_q;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  // Storage entries: cleared on reset, written at the tail on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = !empty;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side prefetch adapter for the ping-pong single-port FIFO.
// Issues RE pulses while read credit remains, captures responses into an
// in-order skid buffer and presents them on a valid/ready stream. An r_err
// (read of an empty FIFO) parks the issuer for RETRY_GAP idle cycles.
// Optional build macro FIFO_RD_STATS_EN adds saturating delivered-word and
// underflow counters; without it rd_cnt/uf_cnt are tied to zero.
module fifo_rd_prefetch #(
  parameter int BUF_DEPTH = 4,
  parameter int RETRY_GAP = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  output logic                       fifo_re,
  input  logic [31:0]                fifo_res,
  input  logic                       fifo_read_valid,
  input  logic                       fifo_r_err,
  output logic [31:0]                m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(BUF_DEPTH):0] inflight,
  output logic                       proto_err,
  output logic [CNT_W-1:0]           rd_cnt,
  output logic [CNT_W-1:0]           uf_cnt
);

  import fifo_rd_prefetch_pkg::*;

  localparam int IW = infl_w(BUF_DEPTH);
  localparam int GW = $clog2(RETRY_GAP) + 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(RETRY_GAP - 1);

  rd_state_e     state_q;
  logic [GW-1:0] gap_q;
  logic [IW-1:0] inflight_q;
  logic [IW-1:0] inflight_d;
  logic          proto_err_q;
  logic          proto_err_d;

  logic [IW-1:0] occ;
  logic [IW:0]   credit;
  logic          credit_ok;
  logic          resp;
  logic          infl_nz;
  logic          resp_ok;
  logic          push;
  logic          pop;

  // Credit uses only registered occupancy and inflight, so a pop this cycle
  // frees credit next cycle and m_ready never reaches fifo_re combinationally.
  assign credit    = (IW+1)'(BUF_DEPTH) - (IW+1)'(occ) - (IW+1)'(inflight_q);
  assign credit_ok = (credit != '0);
  assign fifo_re   = (state_q == ST_ISSUE) && enable && credit_ok;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign resp    = fifo_read_valid || fifo_r_err;
  assign infl_nz = (inflight_q != '0);
  assign resp_ok = resp && infl_nz;
  assign push    = fifo_read_valid && infl_nz;
  assign pop     = m_valid && m_ready;

  // Issue FSM with retry backoff; r_err is honoured in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_r_err) begin
            state_q <= ST_BACKOFF;
            gap_q   <= GAP_LOAD;
          end else if (enable) begin
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (fifo_r_err) begin
            state_q <= ST_BACKOFF;
            gap_q   <= GAP_LOAD;
          end else if (!enable) begin
            state_q <= ST_IDLE;
          end
        end
        ST_BACKOFF: begin
          if (fifo_r_err) begin
            gap_q <= GAP_LOAD;
          end else if (gap_q == '0) begin
            state_q <= enable ? ST_ISSUE : ST_IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gap_q   <= '0;
        end
      endcase
    end
  end

  // Outstanding-request and sticky protocol-error next state.
  always_comb begin
    inflight_d  = inflight_q;
    proto_err_d = proto_err_q;
    case ({fifo_re, resp_ok})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (resp && !infl_nz) begin
      proto_err_d = 1'b1;
    end
  end

  // Outstanding-request counter and sticky protocol-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign inflight  = inflight_q;
  assign proto_err = proto_err_q;

  rd_skid_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (WORD_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (fifo_res),
    .pop_i       (pop),
    .head_o      (m_data),
    .valid_o     (m_valid),
    .occ_o       (occ)
  );

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] uf_cnt_q;

  // Saturating statistics: words delivered and underflow responses seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      uf_cnt_q <= '0;
    end else begin
      if (pop && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if (fifo_r_err && (uf_cnt_q != '1)) begin
        uf_cnt_q <= uf_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign uf_cnt = uf_cnt_q;
`else
  assign rd_cnt = '0;
  assign uf_cnt = '0;
`endif

endmodule
